// File: rtl/prom_arb_if.sv
// PROM arbiter request/grant bundle: requesters drive req/clr_tmo, arbiter drives the rest.
interface prom_arb_if;
  logic [2:0] req;
  logic       clr_tmo;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       prom_ena;
  logic       busy;
  logic       tmo;
  logic       tmo_sticky;
  logic [1:0] arb_state;

  modport master (
    output req, clr_tmo,
    input  gnt, owner, prom_ena, busy, tmo, tmo_sticky, arb_state
  );
  modport slave (
    input  req, clr_tmo,
    output gnt, owner, prom_ena, busy, tmo, tmo_sticky, arb_state
  );
endinterface

// File: rtl/prom_access_arb.sv
// Three-way PROM bus arbiter: req0 fixed priority, req1/req2 round-robin, turnaround gap.
// Watchdog, Abort state and TMO/TMO_STICKY are built only when PROM_ARB_WDOG_EN is defined.
module prom_access_arb #(
  parameter logic [3:0]  TURN    = 4'd3,
  parameter logic [15:0] TMO_CYC = 16'd50000
) (
  input logic       clk_i,
  input logic       rst_n_i,
  prom_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TURNS = 2'b01,
    GRANT = 2'b10,
    ABORT = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] gnt_q, gnt_d;
  logic       ena_q, busy_q;
  logic       own_req;

  assign own_req = bus.req[owner_q];

  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
    if (r[0])         return 2'd0;
    if (r[1] && r[2]) return (last == 2'd1) ? 2'd2 : 2'd1;
    return r[1] ? 2'd1 : 2'd2;
  endfunction

`ifdef PROM_ARB_WDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        tmo_q, tmo_d, sticky_q, sticky_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
`ifdef PROM_ARB_WDOG_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: if (|bus.req) begin
        owner_d = pick(bus.req, last_q);
        tcnt_d  = '0;
        state_d = TURNS;
      end
      TURNS: begin
        if (!own_req) state_d = IDLE;
        else if (tcnt_q == TURN - 4'd1) begin
          state_d = GRANT;
`ifdef PROM_ARB_WDOG_EN
          wd_d    = '0;
`endif
          // req0 wins on priority, so only 1/2 take part in the rotation
          if (owner_q != 2'd0) last_d = owner_q;
        end else if (tcnt_q != 4'hf) tcnt_d = tcnt_q + 4'd1;
      end
      GRANT: begin
        if (!own_req) state_d = IDLE;
`ifdef PROM_ARB_WDOG_EN
        else if (wd_q == TMO_CYC - 16'd1) state_d = ABORT;
        else if (wd_q != 16'hffff)        wd_d = wd_q + 16'd1;
`endif
      end
      ABORT: if (!own_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (3'b001 << owner_d) : 3'b000;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'd2;
      tcnt_q  <= '0;
      gnt_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
      ena_q   <= (state_d == GRANT);
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef PROM_ARB_WDOG_EN
  always_comb begin
    tmo_d    = (state_d == ABORT) && (state_q != ABORT);
    sticky_d = sticky_q;
    // a fresh expiry beats a clear arriving on the same edge
    if (tmo_d)            sticky_d = 1'b1;
    else if (bus.clr_tmo) sticky_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q     <= '0;
      tmo_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.tmo        = tmo_q;
  assign bus.tmo_sticky = sticky_q;
`else
  assign bus.tmo        = 1'b0;
  assign bus.tmo_sticky = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.prom_ena  = ena_q;
  assign bus.busy      = busy_q;
  assign bus.arb_state = state_q;

endmodule

// File: tb/tb_prom_access_arb.sv
// Bench for prom_access_arb: vector table, directed corner sequences, random vs reference model.
module tb_prom_access_arb;
  localparam logic [3:0]  TURN    = 4'd3;
  localparam logic [15:0] TMO_CYC = 16'd20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prom_arb_if bus();
  prom_access_arb #(.TURN(TURN), .TMO_CYC(TMO_CYC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 turnaround, 2 granted, 3 aborted; timing tracked as
  // absolute cycle deadlines rather than counters.
  int   cyc = 0;
  int   m_mode, m_owner, m_last, m_due;
  logic m_tmo, m_sticky;

  function automatic logic [11:0] dut_vec();
    return {bus.gnt, bus.owner, bus.prom_ena, bus.busy, bus.tmo, bus.tmo_sticky, bus.arb_state};
  endfunction

  function automatic logic [11:0] mdl_vec();
    logic [2:0] g;
    g = (m_mode == 2) ? 3'(1 << m_owner) : 3'b000;
    return {g, 2'(m_owner), m_mode == 2, m_mode != 0, m_tmo, m_sticky, 2'(m_mode)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_owner = 0; m_last = 2; m_due = 0; m_tmo = 1'b0; m_sticky = 1'b0;
  endtask

  task automatic m_step(input logic [2:0] r, input logic clr);
    cyc++;
    m_tmo = 1'b0;
    case (m_mode)
      0: if (r != 3'b000) begin
        if (r[0])              m_owner = 0;
        else if (r[1] && r[2]) m_owner = (m_last == 1) ? 2 : 1;
        else                   m_owner = r[1] ? 1 : 2;
        m_mode = 1;
        m_due  = cyc + int'(TURN);
      end
      1: if (!r[m_owner]) m_mode = 0;
         else if (cyc == m_due) begin
           m_mode = 2;
           if (m_owner != 0) m_last = m_owner;
           m_due = cyc + int'(TMO_CYC);
         end
      2: if (!r[m_owner]) m_mode = 0;
`ifdef PROM_ARB_WDOG_EN
         else if (cyc == m_due) begin m_mode = 3; m_tmo = 1'b1; end
`endif
      default: if (!r[m_owner]) m_mode = 0;
    endcase
`ifdef PROM_ARB_WDOG_EN
    if (clr)   m_sticky = 1'b0;
    if (m_tmo) m_sticky = 1'b1;
`endif
  endtask

  task automatic tick(input logic [2:0] r, input logic clr);
    bus.req = r;
    bus.clr_tmo = clr;
    m_step(r, clr);
    @(posedge clk); #1;
    chk("model", dut_vec(), mdl_vec());
  endtask

  task automatic do_reset();
    bus.req = 3'b000;
    bus.clr_tmo = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] own;
    logic [1:0] st;
    logic       ena;
    logic       busy;
  } vec_t;
  vec_t tv[11];

  initial begin
    // single-requester walk: turnaround, grant, release
    for (int i = 0; i < 3; i++)  tv[i] = '{3'b010, 3'b000, 2'd1, 2'b01, 1'b0, 1'b1};
    for (int i = 3; i < 9; i++)  tv[i] = '{3'b010, 3'b010, 2'd1, 2'b10, 1'b1, 1'b1};
    for (int i = 9; i < 11; i++) tv[i] = '{3'b000, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0};

    do_reset();
    chk("reset", dut_vec(), 12'h000);

    for (int i = 0; i < 11; i++) begin
      tick(tv[i].req, 1'b0);
      chk($sformatf("vec%0d", i), {bus.gnt, bus.owner, bus.arb_state, bus.prom_ena, bus.busy},
          {tv[i].gnt, tv[i].own, tv[i].st, tv[i].ena, tv[i].busy});
    end

    // round robin between 1 and 2, each drops for one cycle after 5 grant cycles
    do_reset();
    begin
      int order[$];
      int gaps[$];
      int gcnt, idle;
      logic [2:0] pg, drv;
      gcnt = 0; idle = 0; pg = 3'b000;
      for (int k = 0; k < 200 && order.size() < 4; k++) begin
        drv = 3'b110;
        if (gcnt == 5) drv = 3'b110 & ~bus.gnt;
        tick(drv, 1'b0);
        if (bus.gnt != 3'b000) begin
          if (pg == 3'b000) begin
            order.push_back(int'(bus.owner));
            if (order.size() > 1) gaps.push_back(idle);
            gcnt = 0; idle = 0;
          end
          gcnt++;
        end else idle++;
        pg = bus.gnt;
      end
      chk("rr_count", order.size(), 4);
      foreach (order[j]) chk($sformatf("rr_order%0d", j), order[j], (j % 2 == 0) ? 1 : 2);
      foreach (gaps[j])  chk($sformatf("rr_gap%0d", j), gaps[j], int'(TURN) + 1);
      tick(3'b000, 1'b0);
    end

    // no preemption, then req0 wins after release
    do_reset();
    repeat (int'(TURN) + 1) tick(3'b100, 1'b0);
    chk("pre_g2", bus.gnt, 3'b100);
    repeat (3) begin tick(3'b111, 1'b0); chk("nopreempt", bus.gnt, 3'b100); end
    tick(3'b011, 1'b0); chk("rel2", {bus.gnt, bus.prom_ena}, 4'b0000);
    tick(3'b011, 1'b0); chk("own0", bus.owner, 2'd0);
    repeat (int'(TURN)) tick(3'b011, 1'b0);
    chk("g0", bus.gnt, 3'b001);
    tick(3'b000, 1'b0);

    // abandoned turnaround leaves LAST untouched
    do_reset();
    tick(3'b010, 1'b0); chk("ab_gnt0", bus.gnt, 3'b000);
    tick(3'b000, 1'b0); chk("ab_idle", {bus.arb_state, bus.gnt}, 5'b0);
    tick(3'b110, 1'b0); chk("tie_own", bus.owner, 2'd1);
    repeat (int'(TURN)) tick(3'b110, 1'b0);
    chk("tie_gnt", bus.gnt, 3'b010);
    tick(3'b000, 1'b0);

    // asynchronous reset mid-grant
    do_reset();
    repeat (int'(TURN) + 1) tick(3'b100, 1'b0);
    chk("ar_pre", bus.gnt, 3'b100);
    #2 rst_n = 1'b0;
    #1 chk("arst", {bus.gnt, bus.prom_ena, bus.busy}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (int'(TURN)) tick(3'b100, 1'b0);
    chk("ar_wait", bus.gnt, 3'b000);
    tick(3'b100, 1'b0);
    chk("ar_gnt", bus.gnt, 3'b100);
    tick(3'b000, 1'b0);

`ifdef PROM_ARB_WDOG_EN
    do_reset();
    begin
      int n, k;
      n = 0; k = 0;
      tick(3'b001, 1'b0);
      while (bus.gnt != 3'b001 && k < 20)  begin tick(3'b001, 1'b0); k++; end
      while (bus.gnt == 3'b001 && k < 200) begin n++; tick(3'b001, 1'b0); k++; end
      chk("wd_len", n, int'(TMO_CYC));
      chk("wd_tmo", {bus.gnt, bus.tmo, bus.tmo_sticky, bus.arb_state}, {3'b000, 1'b1, 1'b1, 2'b11});
      tick(3'b001, 1'b0);
      chk("wd_hold", {bus.tmo, bus.tmo_sticky, bus.arb_state}, {1'b0, 1'b1, 2'b11});
      tick(3'b001, 1'b1);
      chk("wd_clr", bus.tmo_sticky, 1'b0);
      tick(3'b000, 1'b0);
      chk("wd_idle", bus.arb_state, 2'b00);
    end
`endif

    // random requests against the reference model
    do_reset();
    begin
      logic [2:0] r;
      r = 3'b000;
      for (int k = 0; k < 3000; k++) begin
        for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
        tick(r, $urandom_range(0, 15) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prom_access_arb.md
Name: prom_access_arb

Overview:
- Arbitrates shared access to the on-board configuration PROM bus among three requesters:
  - req 0: power-up/restore transfer sequencer (PROM-to-flip-flop);
  - req 1: PROM programming sequencer;
  - req 2: slow-control/JTAG user readback.
- Enforces a bus turnaround gap between owners and a watchdog on hung owners.
- Drives the PROM bus mux select and the master enable gating the PROM CE/OE path.

Parameters:
- TURN, 4'd3: idle turnaround cycles between ownership changes, legal 1..15.
- TMO_CYC, 16'd50000: maximum cycles one owner may hold the grant.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  3  request per requester; owner holds high for the whole access, drops to release
- CLR_TMO  in  1  synchronous clear of TMO_STICKY
- GNT  out  3  one-hot grant
- OWNER  out  2  encoded current/pending owner, drives the PROM bus mux select
- PROM_ENA  out  1  master enable for the PROM CE/OE path
- BUSY  out  1  high in any state other than Idle
- TMO  out  1  one-cycle pulse on watchdog expiry
- TMO_STICKY  out  1  set on expiry, held until CLR_TMO or reset
- ARB_STATE  out  2  current state encoding

Behaviour:
- Reset (RST_N low, asynchronous): state Idle. GNT=0, OWNER=0, PROM_ENA=0, BUSY=0, TMO=0, TMO_STICKY=0. Round-robin pointer LAST=2. Turn counter and watchdog counter = 0.
- All outputs are registered, decoded from nextstate. Idle=2'b00, Turn=2'b01, Grant=2'b10, Abort=2'b11.
- Idle:
  - Exits only when any REQ bit is high. Winner is latched into OWNER; go to Turn with the turn counter cleared.
  - Priority: REQ[0] always wins.
  - Otherwise, if only one of REQ[1]/REQ[2] is high, it wins.
  - If both are high, the index not equal to LAST wins.
- Turn:
  - GNT=0, PROM_ENA=0, turn counter increments each cycle.
  - If REQ[OWNER] drops: go to Idle; no grant, LAST unchanged.
  - When the counter reaches TURN-1 with REQ[OWNER] still high: go to Grant. LAST is updated to OWNER only if OWNER is 1 or 2.
- Grant:
  - GNT[OWNER]=1, PROM_ENA=1, watchdog increments each cycle.
  - No preemption: other REQ bits, including REQ[0], are ignored.
  - REQ[OWNER] low: go to Idle. GNT and PROM_ENA are low on that same edge.
  - Watchdog reaches TMO_CYC-1 while REQ[OWNER] is still high: go to Abort.
- Abort:
  - GNT=0, PROM_ENA=0. TMO=1 on the entry cycle only; TMO_STICKY set.
  - Stay until REQ[OWNER] is low, then go to Idle. A re-request from the same owner must first drop.
- Latency: REQ sampled high in Idle at edge 0 → GNT high from edge TURN+1. Minimum gap between consecutive grants is TURN+1 cycles.
- TMO_STICKY: CLR_TMO clears it on the next edge. If an expiry happens on the same edge as CLR_TMO, the set wins.
- OWNER holds its value through Idle until the next arbitration.
- Counters saturate and never wrap. Turn counter is 4 bits, watchdog is 16 bits.

Optional Feature:
- Macro PROM_ARB_WDOG_EN.
- Defined: watchdog, Abort state, TMO and TMO_STICKY behave as above.
- Undefined:
  - Watchdog logic is not built; Grant is held indefinitely until release and Abort is unreachable.
  - TMO and TMO_STICKY are tied 0; CLR_TMO is ignored.

Test Plan:
- TURN=3, REQ=3'b010 from edge 0 → BUSY at edge 1; OWNER=1 at edge 1; GNT=3'b010 and PROM_ENA=1 at edge 4. Drop REQ[1] at edge 10 → GNT=0, PROM_ENA=0, ARB_STATE=00 at edge 10.
- REQ[1] and REQ[2] both held, each dropped for one cycle after 5 grant cycles → grant order 1,2,1,2; minimum gap between grants 4 cycles.
- REQ[2] granted, REQ[0] and REQ[1] raised mid-grant → GNT stays 3'b100. After REQ[2] drops, OWNER=0 and GNT=3'b001 TURN+1 cycles later.
- REQ[1] raised then dropped on the second Turn cycle → no GNT bit ever asserts, return to Idle, LAST still 2. A following REQ[1]/REQ[2] tie grants 1.
- With PROM_ARB_WDOG_EN, TMO_CYC=20, REQ[0] held → GNT=3'b001 for exactly 20 cycles, then GNT=0, TMO high for one cycle, TMO_STICKY=1, ARB_STATE=11 until REQ[0] drops. CLR_TMO pulse → TMO_STICKY=0 next edge.
- RST_N pulled low mid-Grant, between clock edges → GNT, PROM_ENA, BUSY go 0 immediately, without waiting for a clock edge. After release with REQ[2] held, a normal grant follows TURN+1 cycles later.
